// File: rtl/speicher_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// speicher_arbiter_pkg
//   Shared definitions for the memory arbiter:
//     - zustand_t        : arbiter FSM state encoding
//     - MODUS_FEST       : fixed priority, lowest channel index wins
//     - MODUS_RUNDLAUF   : round robin, search starts after the last grant
//     - naechster_index  : successor of a channel index with wrap-around
// ----------------------------------------------------------------------------
package speicher_arbiter_pkg;

    typedef enum logic [1:0] {
        FREI      = 2'd0,   // idle, waiting for a request
        ZUGRIFF   = 2'd1,   // memory access in progress, strobe held high
        ABSCHLUSS = 2'd2    // one-cycle completion, Fertig pulses
    } zustand_t;

    localparam int MODUS_FEST     = 0;
    localparam int MODUS_RUNDLAUF = 1;

    // Index following 'index' in a ring of 'anzahl' channels.
    function automatic int naechster_index(input int index, input int anzahl);
        return (index + 1 >= anzahl) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/speicher_arbiter_auswahl.sv
// ----------------------------------------------------------------------------
// speicher_arbiter_auswahl
//   Combinational channel selection. Starting at i_start, the request vector
//   is scanned upward with wrap-around; the first requesting channel wins.
//   A start index of 0 gives plain fixed priority (lowest index wins).
//
//   Ports:
//     i_anfrage  [ANZAHL_KANAELE] request vector
//     i_start    [IW]             first index to examine
//     o_index    [IW]             selected channel (0 when nothing requested)
//     o_gueltig  [1]              at least one request present
// ----------------------------------------------------------------------------
module speicher_arbiter_auswahl #(
    parameter int ANZAHL_KANAELE = 3,
    parameter int IW             = 2
) (
    input  logic [ANZAHL_KANAELE-1:0] i_anfrage,
    input  logic [IW-1:0]             i_start,
    output logic [IW-1:0]             o_index,
    output logic                      o_gueltig
);

    // Outer loop walks the search order, inner loop finds the channel that
    // sits at that search position; avoids a variable bit-select.
    always_comb begin
        o_gueltig = 1'b0;
        o_index   = '0;
        for (int i = 0; i < ANZAHL_KANAELE; i++) begin
            for (int j = 0; j < ANZAHL_KANAELE; j++) begin
                if (!o_gueltig && i_anfrage[j] &&
                    (j == (int'(i_start) + i) % ANZAHL_KANAELE)) begin
                    o_gueltig = 1'b1;
                    o_index   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/speicher_arbiter.sv
// ----------------------------------------------------------------------------
// speicher_arbiter
//   Arbitrates several masters (0 = instruction fetch, 1 = data read,
//   2 = data write by default) onto one memory port.
//   FSM: FREI -> ZUGRIFF -> ABSCHLUSS -> FREI.
//
//   Handshake: a master raises Anfrage[k] and holds it until Fertig[k]
//   pulses. Address, write data and access type are captured at grant time,
//   so later changes (or a dropped Anfrage) do not disturb the running
//   access. On the memory side the selected strobe stays high throughout
//   ZUGRIFF until SpeicherFertig is seen (or the timeout expires).
//
//   Ports:
//     Clock, Reset            clock, synchronous active-high reset
//     Anfrage [N]             per-channel request level
//     Schreiben [N]           per-channel access type (1 = write)
//     Adresse [N*AW]          packed per-channel addresses
//     DatenRaus [N*DW]        packed per-channel write data
//     Fertig [N]              completion pulse to the granted channel
//     Fehler [N]              timeout pulse, coincident with Fertig
//     DatenRein [DW]          registered read data (0 after a timeout)
//     SpeicherAdresse [AW]    memory address
//     SpeicherSchreibDaten    memory write data
//     SpeicherLesen           read strobe
//     SpeicherSchreiben       write strobe
//     SpeicherLeseDaten [DW]  memory read data
//     SpeicherFertig          memory response (read data valid / write done)
//     ZustandDebug [2]        current FSM state
// ----------------------------------------------------------------------------
module speicher_arbiter
    import speicher_arbiter_pkg::*;
#(
    parameter int ANZAHL_KANAELE = 3,
    parameter int DATEN_BREITE   = 32,
    parameter int ADRESS_BREITE  = 32,
    parameter int MODUS          = 0,
    parameter int TIMEOUT_ZYKLEN = 255
) (
    input  logic                                    Clock,
    input  logic                                    Reset,
    input  logic [ANZAHL_KANAELE-1:0]               Anfrage,
    input  logic [ANZAHL_KANAELE-1:0]               Schreiben,
    input  logic [ANZAHL_KANAELE*ADRESS_BREITE-1:0] Adresse,
    input  logic [ANZAHL_KANAELE*DATEN_BREITE-1:0]  DatenRaus,
    output logic [ANZAHL_KANAELE-1:0]               Fertig,
    output logic [ANZAHL_KANAELE-1:0]               Fehler,
    output logic [DATEN_BREITE-1:0]                 DatenRein,
    output logic [ADRESS_BREITE-1:0]                SpeicherAdresse,
    output logic [DATEN_BREITE-1:0]                 SpeicherSchreibDaten,
    output logic                                    SpeicherLesen,
    output logic                                    SpeicherSchreiben,
    input  logic [DATEN_BREITE-1:0]                 SpeicherLeseDaten,
    input  logic                                    SpeicherFertig,
    output logic [1:0]                              ZustandDebug
);

    localparam int IW = $clog2(ANZAHL_KANAELE);
    // Counter only has to reach TIMEOUT_ZYKLEN-1.
    localparam int TW = (TIMEOUT_ZYKLEN > 1) ? $clog2(TIMEOUT_ZYKLEN) : 1;
    localparam int GRENZE = (TIMEOUT_ZYKLEN > 0) ? TIMEOUT_ZYKLEN - 1 : 0;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    zustand_t                      r_zustand;
    logic [IW-1:0]                 r_kanal;
    logic [IW-1:0]                 r_start;
    logic                          r_ist_schreiben;
    logic [TW-1:0]                 r_zaehler;
    logic [ADRESS_BREITE-1:0]      r_adresse;
    logic [DATEN_BREITE-1:0]       r_schreib_daten;
    logic [DATEN_BREITE-1:0]       r_daten_rein;
    logic                          r_lesen;
    logic                          r_schreiben;
    logic [ANZAHL_KANAELE-1:0]     r_fertig;
    logic [ANZAHL_KANAELE-1:0]     r_fehler;

    // ------------------------------------------------------------------------
    // Unpack the per-channel buses
    // ------------------------------------------------------------------------
    logic [ADRESS_BREITE-1:0] w_adr_feld  [ANZAHL_KANAELE];
    logic [DATEN_BREITE-1:0]  w_wdat_feld [ANZAHL_KANAELE];

    for (genvar gk = 0; gk < ANZAHL_KANAELE; gk++) begin : g_entpacken
        assign w_adr_feld[gk]  = Adresse[gk*ADRESS_BREITE +: ADRESS_BREITE];
        assign w_wdat_feld[gk] = DatenRaus[gk*DATEN_BREITE +: DATEN_BREITE];
    end

    // ------------------------------------------------------------------------
    // Channel selection
    // ------------------------------------------------------------------------
    logic [IW-1:0]             w_start;
    logic [IW-1:0]             w_index;
    logic                      w_gueltig;
    logic                      w_timeout;
    logic [ANZAHL_KANAELE-1:0] w_kanal_maske;

    // Fixed priority always scans from channel 0.
    assign w_start = (MODUS == MODUS_RUNDLAUF) ? r_start : '0;

    speicher_arbiter_auswahl #(
        .ANZAHL_KANAELE (ANZAHL_KANAELE),
        .IW             (IW)
    ) u_auswahl (
        .i_anfrage (Anfrage),
        .i_start   (w_start),
        .o_index   (w_index),
        .o_gueltig (w_gueltig)
    );

    assign w_timeout     = (TIMEOUT_ZYKLEN != 0) && (r_zaehler == TW'(GRENZE));
    assign w_kanal_maske = {{(ANZAHL_KANAELE-1){1'b0}}, 1'b1} << r_kanal;

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_zustand       <= FREI;
            r_kanal         <= '0;
            r_start         <= '0;
            r_ist_schreiben <= 1'b0;
            r_zaehler       <= '0;
            r_adresse       <= '0;
            r_schreib_daten <= '0;
            r_daten_rein    <= '0;
            r_lesen         <= 1'b0;
            r_schreiben     <= 1'b0;
            r_fertig        <= '0;
            r_fehler        <= '0;
        end else begin
            // Completion flags are single-cycle pulses.
            r_fertig <= '0;
            r_fehler <= '0;

            case (r_zustand)
                FREI: begin
                    if (w_gueltig) begin
                        r_kanal         <= w_index;
                        r_adresse       <= w_adr_feld[w_index];
                        r_schreib_daten <= w_wdat_feld[w_index];
                        r_ist_schreiben <= Schreiben[w_index];
                        r_lesen         <= !Schreiben[w_index];
                        r_schreiben     <= Schreiben[w_index];
                        r_zaehler       <= '0;
                        r_start         <= IW'(naechster_index(int'(w_index), ANZAHL_KANAELE));
                        r_zustand       <= ZUGRIFF;
                    end
                end

                ZUGRIFF: begin
                    // A response in the limit cycle still counts as success,
                    // so SpeicherFertig is checked before the timeout.
                    if (SpeicherFertig) begin
                        r_lesen     <= 1'b0;
                        r_schreiben <= 1'b0;
                        if (!r_ist_schreiben) begin
                            r_daten_rein <= SpeicherLeseDaten;
                        end
                        r_fertig  <= w_kanal_maske;
                        r_zustand <= ABSCHLUSS;
                    end else if (w_timeout) begin
                        r_lesen      <= 1'b0;
                        r_schreiben  <= 1'b0;
                        r_daten_rein <= '0;
                        r_fertig     <= w_kanal_maske;
                        r_fehler     <= w_kanal_maske;
                        r_zustand    <= ABSCHLUSS;
                    end else if (TIMEOUT_ZYKLEN != 0) begin
                        r_zaehler <= r_zaehler + 1'b1;
                    end
                end

                ABSCHLUSS: begin
                    // Requests are not looked at here; the master sees Fertig
                    // this cycle and can drop Anfrage before the next scan.
                    r_zustand <= FREI;
                end

                default: begin
                    r_zustand <= FREI;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Fertig               = r_fertig;
    assign Fehler               = r_fehler;
    assign DatenRein            = r_daten_rein;
    assign SpeicherAdresse      = r_adresse;
    assign SpeicherSchreibDaten = r_schreib_daten;
    assign SpeicherLesen        = r_lesen;
    assign SpeicherSchreiben    = r_schreiben;
    assign ZustandDebug         = r_zustand;

endmodule

// File: tb/tb_speicher_arbiter.sv
// ----------------------------------------------------------------------------
// tb_speicher_arbiter
//   Three arbiter instances share clock and reset:
//     inst 0 : fixed priority, default timeout
//     inst 1 : round robin
//     inst 2 : fixed priority, timeout of 4 cycles
//   Directed vectors with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_speicher_arbiter;

    logic Clock;
    logic Reset;

    logic [2:0]  anfrage     [3];
    logic [2:0]  schreiben   [3];
    logic [95:0] adresse     [3];
    logic [95:0] daten_raus  [3];
    logic [31:0] lese_daten  [3];
    logic        sp_fertig   [3];

    logic [2:0]  fertig      [3];
    logic [2:0]  fehler      [3];
    logic [31:0] daten_rein  [3];
    logic [31:0] sp_adr      [3];
    logic [31:0] sp_wdat     [3];
    logic        sp_lesen    [3];
    logic        sp_schreiben[3];
    logic [1:0]  zustand     [3];

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ------------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------------
    speicher_arbiter #(.MODUS(0)) u_fest (
        .Clock(Clock), .Reset(Reset),
        .Anfrage(anfrage[0]), .Schreiben(schreiben[0]),
        .Adresse(adresse[0]), .DatenRaus(daten_raus[0]),
        .Fertig(fertig[0]), .Fehler(fehler[0]), .DatenRein(daten_rein[0]),
        .SpeicherAdresse(sp_adr[0]), .SpeicherSchreibDaten(sp_wdat[0]),
        .SpeicherLesen(sp_lesen[0]), .SpeicherSchreiben(sp_schreiben[0]),
        .SpeicherLeseDaten(lese_daten[0]), .SpeicherFertig(sp_fertig[0]),
        .ZustandDebug(zustand[0])
    );

    speicher_arbiter #(.MODUS(1)) u_rr (
        .Clock(Clock), .Reset(Reset),
        .Anfrage(anfrage[1]), .Schreiben(schreiben[1]),
        .Adresse(adresse[1]), .DatenRaus(daten_raus[1]),
        .Fertig(fertig[1]), .Fehler(fehler[1]), .DatenRein(daten_rein[1]),
        .SpeicherAdresse(sp_adr[1]), .SpeicherSchreibDaten(sp_wdat[1]),
        .SpeicherLesen(sp_lesen[1]), .SpeicherSchreiben(sp_schreiben[1]),
        .SpeicherLeseDaten(lese_daten[1]), .SpeicherFertig(sp_fertig[1]),
        .ZustandDebug(zustand[1])
    );

    speicher_arbiter #(.MODUS(0), .TIMEOUT_ZYKLEN(4)) u_to (
        .Clock(Clock), .Reset(Reset),
        .Anfrage(anfrage[2]), .Schreiben(schreiben[2]),
        .Adresse(adresse[2]), .DatenRaus(daten_raus[2]),
        .Fertig(fertig[2]), .Fehler(fehler[2]), .DatenRein(daten_rein[2]),
        .SpeicherAdresse(sp_adr[2]), .SpeicherSchreibDaten(sp_wdat[2]),
        .SpeicherLesen(sp_lesen[2]), .SpeicherSchreiben(sp_schreiben[2]),
        .SpeicherLeseDaten(lese_daten[2]), .SpeicherFertig(sp_fertig[2]),
        .ZustandDebug(zustand[2])
    );

    // ------------------------------------------------------------------------
    // Checking / driver tasks
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] ist, input logic [63:0] soll);
        n_tests++;
        if (ist !== soll) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, ist, soll);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns later.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Runs one access on instance 'inst' whose request for 'kanal' is already
    // raised. The memory answers on the (warte+1)-th strobe cycle.
    task automatic zugriff(input int inst, input int kanal, input int warte,
                           input logic [31:0] rdat,
                           output int n_strobe, output int n_fertig,
                           output int n_fremd, output int n_fehler,
                           output logic [31:0] adr);
        logic [2:0] maske;
        logic       strobe;
        maske    = 3'b001 << kanal;
        n_strobe = 0;
        n_fertig = 0;
        n_fremd  = 0;
        n_fehler = 0;
        adr      = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            strobe = sp_lesen[inst] | sp_schreiben[inst];
            if (strobe) begin
                n_strobe++;
                if (n_strobe == 1) adr = sp_adr[inst];
            end
            if (fertig[inst] == maske) begin
                n_fertig++;
                anfrage[inst][kanal] = 1'b0;
            end else if (fertig[inst] != 3'b000) begin
                n_fremd++;
            end
            if (fehler[inst] != 3'b000) begin
                n_fehler++;
                if (fehler[inst] != maske || fertig[inst] != maske) n_fremd++;
            end
            sp_fertig[inst]  = strobe && (n_strobe == warte + 1);
            lese_daten[inst] = rdat;
        end
        sp_fertig[inst] = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int          ns, nf, nx, ne;
    logic [31:0] adr;
    logic [31:0] rr_adr [5];
    int          got;

    initial begin
        for (int i = 0; i < 3; i++) begin
            anfrage[i]    = '0;
            schreiben[i]  = '0;
            adresse[i]    = '0;
            daten_raus[i] = '0;
            lese_daten[i] = '0;
            sp_fertig[i]  = 1'b0;
        end
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk("reset_zustand", zustand[i], 2'd0);
            chk("reset_strobes", {sp_lesen[i], sp_schreiben[i]}, 2'b00);
            chk("reset_fertig_fehler", {fertig[i], fehler[i]}, 6'd0);
            chk("reset_daten_rein", daten_rein[i], 32'h0);
            chk("reset_sp_adr_wdat", {sp_adr[i], sp_wdat[i]}, 64'h0);
        end

        // Fixed priority: channels 0 and 2 together
        anfrage[0] = 3'b101;
        adresse[0] = {32'h20, 32'h0, 32'h10};
        step();
        chk("fest_erst_k0_lesen", sp_lesen[0], 1'b1);
        chk("fest_erst_k0_adr", sp_adr[0], 32'h10);
        chk("fest_zugriff_zustand", zustand[0], 2'd1);
        sp_fertig[0]  = 1'b1;
        lese_daten[0] = 32'h1111_1111;
        step();
        chk("fest_k0_fertig", fertig[0], 3'b001);
        chk("fest_k0_daten", daten_rein[0], 32'h1111_1111);
        chk("fest_abschluss_strobe", sp_lesen[0], 1'b0);
        sp_fertig[0] = 1'b0;
        anfrage[0]   = 3'b100;
        step();
        chk("fest_frei_fertig", fertig[0], 3'b000);
        chk("fest_frei_zustand", zustand[0], 2'd0);
        step();
        chk("fest_k2_adr", sp_adr[0], 32'h20);
        chk("fest_k2_lesen", sp_lesen[0], 1'b1);
        sp_fertig[0]  = 1'b1;
        lese_daten[0] = 32'h2222_2222;
        step();
        chk("fest_k2_fertig", fertig[0], 3'b100);
        chk("fest_k2_daten", daten_rein[0], 32'h2222_2222);
        sp_fertig[0] = 1'b0;
        anfrage[0]   = 3'b000;
        step();

        // SpeicherFertig while idle is ignored
        sp_fertig[0]  = 1'b1;
        lese_daten[0] = 32'h3333_3333;
        step();
        sp_fertig[0] = 1'b0;
        chk("frei_sf_zustand", zustand[0], 2'd0);
        chk("frei_sf_fertig", fertig[0], 3'b000);
        chk("frei_sf_daten", daten_rein[0], 32'h2222_2222);

        // Write on channel 1; inputs change and Anfrage drops mid-access
        anfrage[0]    = 3'b010;
        schreiben[0]  = 3'b010;
        adresse[0]    = {32'h0, 32'h44, 32'h0};
        daten_raus[0] = {32'h0, 32'hCAFE_F00D, 32'h0};
        step();
        chk("schreib_strobes", {sp_lesen[0], sp_schreiben[0]}, 2'b01);
        chk("schreib_wdat", sp_wdat[0], 32'hCAFE_F00D);
        chk("schreib_adr", sp_adr[0], 32'h44);
        adresse[0]    = {32'h0, 32'h55, 32'h0};
        daten_raus[0] = {32'h0, 32'h0BAD_BAD0, 32'h0};
        anfrage[0]    = 3'b000;
        step();
        chk("schreib_halt_adr", sp_adr[0], 32'h44);
        chk("schreib_halt_wdat", sp_wdat[0], 32'hCAFE_F00D);
        chk("schreib_halt_strobe", sp_schreiben[0], 1'b1);
        sp_fertig[0]  = 1'b1;
        lese_daten[0] = 32'h9999_9999;
        step();
        chk("schreib_fertig", fertig[0], 3'b010);
        chk("schreib_daten_rein_unveraendert", daten_rein[0], 32'h2222_2222);
        sp_fertig[0] = 1'b0;
        schreiben[0] = 3'b000;
        step();

        // Read on channel 1 with three wait cycles
        adresse[0] = {32'h0, 32'h100, 32'h0};
        anfrage[0] = 3'b010;
        zugriff(0, 1, 3, 32'hDEAD_BEEF, ns, nf, nx, ne, adr);
        chk("warte_strobe_zyklen", ns, 4);
        chk("warte_fertig_pulse", nf, 1);
        chk("warte_fremde_pulse", nx, 0);
        chk("warte_fehler", ne, 0);
        chk("warte_adr", adr, 32'h100);
        chk("warte_daten", daten_rein[0], 32'hDEAD_BEEF);

        // Round robin with all three requesting continuously
        anfrage[1] = 3'b111;
        adresse[1] = {32'h1002, 32'h1001, 32'h1000};
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            step();
            if (sp_lesen[1]) begin
                rr_adr[got] = sp_adr[1];
                got++;
                sp_fertig[1] = 1'b1;
            end else begin
                sp_fertig[1] = 1'b0;
            end
        end
        step();
        sp_fertig[1] = 1'b0;
        anfrage[1]   = 3'b000;
        step();
        step();
        chk("rr_anzahl", got, 5);
        chk("rr_0", rr_adr[0], 32'h1000);
        chk("rr_1", rr_adr[1], 32'h1001);
        chk("rr_2", rr_adr[2], 32'h1002);
        chk("rr_3", rr_adr[3], 32'h1000);
        chk("rr_4", rr_adr[4], 32'h1001);

        // Response exactly in the timeout-limit cycle: normal completion
        adresse[2] = {32'h0, 32'h0, 32'h200};
        anfrage[2] = 3'b001;
        zugriff(2, 0, 3, 32'h1234_5678, ns, nf, nx, ne, adr);
        chk("grenze_strobe_zyklen", ns, 4);
        chk("grenze_fertig", nf, 1);
        chk("grenze_fehler", ne, 0);
        chk("grenze_fremd", nx, 0);
        chk("grenze_daten", daten_rein[2], 32'h1234_5678);

        // Memory never answers: timeout
        anfrage[2] = 3'b001;
        zugriff(2, 0, 1000, 32'hFFFF_FFFF, ns, nf, nx, ne, adr);
        chk("timeout_strobe_zyklen", ns, 4);
        chk("timeout_fertig", nf, 1);
        chk("timeout_fehler", ne, 1);
        chk("timeout_gleichzeitig", nx, 0);
        chk("timeout_daten", daten_rein[2], 32'h0);

        // Reset in the second ZUGRIFF cycle
        adresse[0] = {32'h300, 32'h140, 32'h0};
        anfrage[0] = 3'b100;
        step();
        step();
        chk("rst_zugriff_strobe", sp_lesen[0], 1'b1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst_strobes_weg", {sp_lesen[0], sp_schreiben[0]}, 2'b00);
        chk("rst_kein_fertig", fertig[0], 3'b000);
        chk("rst_zustand", zustand[0], 2'd0);
        chk("rst_daten_rein", daten_rein[0], 32'h0);
        anfrage[0] = 3'b010;
        zugriff(0, 1, 0, 32'hA5A5_A5A5, ns, nf, nx, ne, adr);
        chk("rst_danach_strobe", ns, 1);
        chk("rst_danach_fertig", nf, 1);
        chk("rst_danach_fremd", nx, 0);
        chk("rst_danach_adr", adr, 32'h140);
        chk("rst_danach_daten", daten_rein[0], 32'hA5A5_A5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
